// File: rtl/diff_lsb_isolate.sv
// Isolates the lowest differing bit of rs^rt as a one-hot word plus an all-equal flag.
// Two register stages, one result per cycle; in_ready = !s1_valid || !s2_valid || out_ready.
module diff_lsb_isolate #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_zero
);

  typedef struct packed {
    logic [WIDTH-1:0] onehot;
    logic             zero;
  } res_t;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic             s2_valid;
  res_t             s2_res;

  logic             s2_free;
  logic             s1_adv;
  logic             in_fire;
  logic [WIDTH-1:0] s1_neg;
  res_t             s1_res;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign in_fire  = in_valid && in_ready;

  // x & -x keeps only the lowest set bit; the negate wraps at WIDTH bits.
  assign s1_neg        = ~s1_x + WIDTH'(1);
  assign s1_res.onehot = s1_x & s1_neg;
  assign s1_res.zero   = (s1_x == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_x     <= rs ^ rt;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_res   <= s1_res;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid  = s2_valid;
  assign out_onehot = s2_res.onehot;
  assign out_zero   = s2_res.zero;

endmodule

// File: doc/diff_lsb_isolate.md
# diff_lsb_isolate

Pipelined front end of the DIFF datapath. Accepts two 32-bit operands, forms their bitwise XOR, and isolates the least-significant differing bit as a one-hot word. The one-hot word and a zero flag go to the downstream one-hot-to-position encoder, which maps bit k to k+1 and all-zero to 33. Uses a valid/ready handshake on both sides: two register stages, one result per cycle, full backpressure.

## Interface
- WIDTH, 32, operand and one-hot width; the downstream encoder requires 32.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair on rs/rt is valid.
- in_ready  output  1  block accepts the pair this cycle.
- rs  input  WIDTH  first operand.
- rt  input  WIDTH  second operand.
- out_valid  output  1  out_onehot/out_zero hold a result.
- out_ready  input  1  downstream consumes the result this cycle.
- out_onehot  output  WIDTH  lowest set bit of rs^rt, all others 0.
- out_zero  output  1  high when rs==rt (out_onehot is 0).

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Stage 1 (s1_valid, s1_x):
  - On an input transfer, load s1_x = rs ^ rt and set s1_valid=1.
  - If stage 1 advances with no new input, clear s1_valid.
- Stage 2 (s2_valid, s2_onehot, s2_zero):
  - On a stage-1 advance, load s2_onehot = s1_x & ((~s1_x + 1) mod 2^WIDTH) and s2_zero = (s1_x == 0).
  - If stage 2 drains with no advance from stage 1, clear s2_valid.
- Advance conditions:
  - s2_free = !s2_valid || out_ready.
  - Stage 1 advances when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational from out_ready, which is intentional.
- Outputs: out_valid=s2_valid, out_onehot=s2_onehot, out_zero=s2_zero.
- Arithmetic: the two's-complement negate wraps at WIDTH bits.
  - s1_x=0 gives onehot 0 and zero=1.
  - s1_x with only bit 31 set gives 0x8000_0000.
  - The result always has at most one bit set.
- Ordering: strictly FIFO. No result is dropped or duplicated, whatever the out_ready pattern.
- Stability: while out_valid=1 and out_ready=0, out_onehot and out_zero hold constant.
- Capacity: two results in flight. When both stages are full and out_ready=0, in_ready=0.
- Data registers load only on the transfers above. They are not required to clear when their valid drops.
- Reset: asynchronous, effective immediately.
  - Clears s1_valid, s2_valid, s1_x, s2_onehot and s2_zero.
  - Therefore out_valid=0, out_onehot=0, out_zero=0, and in_ready=1 during and after reset.
  - Reset asserted mid-operation discards all in-flight results. The first input after release produces a result 2 cycles later.

## Timing
- Latency: input transfer at edge N gives out_valid=1 after edge N+1, with out_ready high from N. The result is available to the downstream encoder in the cycle after N+1.
- Throughput: 1 transfer/cycle sustained when out_ready=1.
- Simultaneous events with both stages full and out_ready=1:
  - Output transfer, stage-1 advance and input transfer all occur on the same edge.
  - No bubble is inserted.
- Backpressure release: out_ready rising with both stages full raises in_ready in the same cycle (combinational).
- No combinational path from rs/rt to any output.

## Test plan
- rs=0x0000_00F0, rt=0x0000_0030, out_ready=1 -> out_onehot=0x0000_0040, out_zero=0, out_valid exactly 2 edges after acceptance.
- rs=rt=0xDEAD_BEEF -> out_onehot=0, out_zero=1 (downstream encoder yields 33). rs=0x8000_0000, rt=0 -> out_onehot=0x8000_0000.
- Back-to-back 5 pairs with out_ready=1 -> 5 results on consecutive cycles in order, in_ready constantly 1.
- out_ready=0 with inputs presented every cycle:
  - Two pairs accepted, then in_ready=0; out_onehot stays on the first result.
  - Release out_ready -> results drain in order, in_ready=1 that cycle.
- Assert rst for 1 cycle with 2 results in flight:
  - out_valid=0, outputs 0 and in_ready=1 immediately.
  - No stale result afterwards; the next pair returns after 2 edges.
